data_memory_responder: RTL

- Memory-side responder for the load/store unit's data-memory interface. Serves load reads with a fixed `LOAD_WAIT`-cycle latency and performs store commits drained from the store buffer.
- Forwards stores that commit while a load is in flight, so every load returns memory state as of its response cycle.
- Sits between the load/store unit and the data memory array. Replaces the ideal memory model used in the testbenches.

---
 rtl/data_memory_responder_pkg.sv | 16 +
 rtl/data_memory_responder_if.sv | 19 +
 rtl/data_memory_responder_array.sv | 17 +
 rtl/data_memory_responder.sv | 59 +++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: widths, load latency and load-stage record shared with the load/store unit
package data_memory_responder_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int DEPTH_LOG2 = 10;
    localparam int LOAD_WAIT  = 2;
    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef struct packed {
        logic                  valid;
        idx_t                  idx;
        logic [DATA_WIDTH-1:0] data;
    } load_stage_t;
    function automatic idx_t to_idx(input logic [ADDR_WIDTH-1:0] loc);
        return loc[DEPTH_LOG2-1:0];
    endfunction
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: load request/response and store commit bus between load/store unit and memory
interface data_memory_responder_if;
    import data_memory_responder_pkg::*;
    logic [ADDR_WIDTH-1:0] mem_location;
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_data_valid;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [ADDR_WIDTH-1:0] commit_location;
    logic                  commit_valid;
    modport master (
        output mem_location, mem_valid, commit_data, commit_location, commit_valid,
        input  mem_data, mem_data_valid
    );
    modport slave (
        input  mem_location, mem_valid, commit_data, commit_location, commit_valid,
        output mem_data, mem_data_valid
    );
endinterface

// File: rtl/data_memory_responder_array.sv
// data_memory_array: zero-initialised word storage, one sync write port, one write-first comb read port
module data_memory_array #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW] = '{default: '0};
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_comb rdata = (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency load pipeline with store forwarding, store commit, and counters
module data_memory_responder
    import data_memory_responder_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    data_memory_responder_if.slave  bus,
    output logic [15:0]             load_count,
    output logic [15:0]             store_count
);
    idx_t                  rd_idx;
    idx_t                  wr_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    load_stage_t           stage_q [LOAD_WAIT];
    load_stage_t           stage_d [LOAD_WAIT];
    logic [15:0]           load_count_q, load_count_d;
    logic [15:0]           store_count_q, store_count_d;
    always_comb begin
        rd_idx = to_idx(bus.mem_location);
        wr_idx = to_idx(bus.commit_location);
    end
    data_memory_array #(.DW(DATA_WIDTH), .AW(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (bus.commit_valid),
        .waddr (wr_idx),
        .wdata (bus.commit_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );
    // in-flight loads pick up any store committed to their index as they advance
    always_comb begin
        stage_d[0] = '{valid: bus.mem_valid && !flush, idx: rd_idx, data: rd_data};
        for (int i = 1; i < LOAD_WAIT; i++) begin
            stage_d[i]       = stage_q[i-1];
            stage_d[i].valid = stage_q[i-1].valid && !flush;
            stage_d[i].data  = (bus.commit_valid && wr_idx == stage_q[i-1].idx) ? bus.commit_data : stage_q[i-1].data;
        end
        load_count_d  = load_count_q + 16'(stage_d[0].valid);
        store_count_d = store_count_q + 16'(bus.commit_valid);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LOAD_WAIT; i++) stage_q[i].valid <= 1'b0;
            load_count_q  <= '0;
            store_count_q <= '0;
        end else begin
            stage_q       <= stage_d;
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
        end
    end
    always_comb begin
        bus.mem_data_valid = stage_q[LOAD_WAIT-1].valid;
        bus.mem_data       = stage_q[LOAD_WAIT-1].valid ? stage_q[LOAD_WAIT-1].data : '0;
        load_count         = load_count_q;
        store_count        = store_count_q;
    end
endmodule
